// File: rtl/hazard3_apb_dma.sv
// hazard3_apb_dma: APB-programmed single-channel memory-copy engine driving one non-bursting AHB5 master.
// Define HAZARD3_DMA_FILL_EN to add CSR.FILL and PATTERN (constant-pattern fill, write-only transfers).
module hazard3_apb_dma #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [W_ADDR-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic              hexcl,
    input  logic              hready,
    input  logic              hresp,
    output logic [W_DATA-1:0] hwdata,
    input  logic [W_DATA-1:0] hrdata,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [15:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] REG_CSR     = 3'd0;
    localparam logic [2:0] REG_SRC     = 3'd1;
    localparam logic [2:0] REG_DST     = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_PATTERN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W_ADDR-1:0] r_src;
    logic [W_ADDR-1:0] r_dst;
    logic [15:0]       r_count;
    logic              r_irq_en;
    logic              r_done;
    logic              r_err;
    logic              r_abort;
    logic [W_DATA-1:0] r_buf;
    logic [W_DATA-1:0] r_hwdata;

    logic              w_apb_wr;
    logic              w_csr_wr;
    logic              w_busy;
    logic              w_start;
    logic              w_go;
    logic              w_zero_done;
    logic              w_fill;
    logic [31:0]       w_pattern;
    logic              w_latch_rd;
    logic              w_load_wd;
    logic              w_word_done;
    logic              w_set_done;
    logic              w_set_err;
    logic [1:0]        w_htrans;
    logic              w_hwrite;
    logic [W_ADDR-1:0] w_haddr;
    logic [31:0]       w_rdata;
    logic              w_unused_paddr;

    assign w_apb_wr    = psel & penable & pwrite;
    assign w_csr_wr    = w_apb_wr & (paddr[4:2] == REG_CSR);
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = w_csr_wr & pwdata[0] & ~w_busy;
    assign w_go        = w_start & (r_count != 16'd0);
    assign w_zero_done = w_start & (r_count == 16'd0);
    assign w_unused_paddr = &{1'b0, paddr[15:5], paddr[1:0]};

`ifdef HAZARD3_DMA_FILL_EN
    logic        r_fill;
    logic [31:0] r_pattern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
        end else begin
            if (w_csr_wr) begin
                r_fill <= pwdata[6];
            end
            if (w_apb_wr && (paddr[4:2] == REG_PATTERN)) begin
                r_pattern <= pwdata;
            end
        end
    end

    assign w_fill    = r_fill;
    assign w_pattern = r_pattern;
`else
    assign w_fill    = 1'b0;
    assign w_pattern = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address phase is driven only in *_A states; data phases leave the bus IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_htrans    = HTRANS_IDLE;
        w_hwrite    = 1'b0;
        w_haddr     = '0;
        w_latch_rd  = 1'b0;
        w_load_wd   = 1'b0;
        w_word_done = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = w_fill ? S_WR_A : S_RD_A;
                end
            end
            S_RD_A: begin
                w_htrans = HTRANS_NONSEQ;
                w_haddr  = r_src;
                if (hready) begin
                    w_state_nxt = S_RD_D;
                end
            end
            S_RD_D: begin
                if (hready) begin
                    w_latch_rd  = 1'b1;
                    w_state_nxt = S_WR_A;
                end else if (hresp) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_A: begin
                w_htrans = HTRANS_NONSEQ;
                w_hwrite = 1'b1;
                w_haddr  = r_dst;
                if (hready) begin
                    w_load_wd   = 1'b1;
                    w_state_nxt = S_WR_D;
                end
            end
            S_WR_D: begin
                if (hready) begin
                    w_word_done = 1'b1;
                    if (r_count == 16'd1) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = w_fill ? S_WR_A : S_RD_A;
                    end
                end else if (hresp) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_count  <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_abort  <= 1'b0;
            r_buf    <= '0;
            r_hwdata <= '0;
        end else begin
            if (w_apb_wr && !w_busy) begin
                case (paddr[4:2])
                    REG_SRC:   r_src   <= {pwdata[W_ADDR-1:2], 2'b00};
                    REG_DST:   r_dst   <= {pwdata[W_ADDR-1:2], 2'b00};
                    REG_COUNT: r_count <= pwdata[15:0];
                    default:   ;
                endcase
            end
            if (w_word_done) begin
                r_src   <= w_fill ? r_src : r_src + W_ADDR'(4);
                r_dst   <= r_dst + W_ADDR'(4);
                r_count <= r_count - 16'd1;
            end
            if (w_latch_rd) begin
                r_buf <= hrdata;
            end
            if (w_load_wd) begin
                r_hwdata <= w_fill ? W_DATA'(w_pattern) : r_buf;
            end
            if (w_csr_wr) begin
                r_irq_en <= pwdata[4];
                if (pwdata[2]) r_done <= 1'b0;
                if (pwdata[3]) r_err  <= 1'b0;
            end
            // Hardware set follows the W1C so a same-cycle completion is never lost.
            if (w_go) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_set_done || w_zero_done) r_done <= 1'b1;
            if (w_set_err) r_err <= 1'b1;
            if (w_csr_wr && pwdata[5] && w_busy) r_abort <= 1'b1;
            if (w_state_nxt == S_IDLE) r_abort <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (psel && !pwrite) begin
            case (paddr[4:2])
                REG_CSR:     w_rdata = {25'd0, w_fill, 1'b0, r_irq_en, r_err, r_done, w_busy, 1'b0};
                REG_SRC:     w_rdata = 32'(r_src);
                REG_DST:     w_rdata = 32'(r_dst);
                REG_COUNT:   w_rdata = {16'd0, r_count};
                REG_PATTERN: w_rdata = w_pattern;
                default:     w_rdata = '0;
            endcase
        end
    end

    assign prdata    = w_rdata;
    assign pready    = 1'b1;
    assign pslverr   = w_apb_wr & w_busy &
                       ((paddr[4:2] == REG_SRC) | (paddr[4:2] == REG_DST) | (paddr[4:2] == REG_COUNT));
    assign irq       = r_irq_en & (r_done | r_err);

    assign haddr     = w_haddr;
    assign hwrite    = w_hwrite;
    assign htrans    = w_htrans;
    assign hwdata    = r_hwdata;
    assign hsize     = 3'd2;
    assign hburst    = 3'd0;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;
    assign hexcl     = 1'b0;

endmodule

// File: tb/tb_hazard3_apb_dma.sv
// Directed bench for hazard3_apb_dma: APB programming plus a behavioural AHB slave with wait/error injection.
`timescale 1ns/1ps
module tb_hazard3_apb_dma;

    localparam logic [15:0] A_CSR = 16'h00, A_SRC = 16'h04, A_DST = 16'h08;
    localparam logic [15:0] A_CNT = 16'h0C, A_PAT = 16'h10, A_BAD = 16'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hexcl;
    logic        hready;
    logic        hresp;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    always #5 clk = ~clk;

    hazard3_apb_dma dut (
        .clk(clk), .rst_n(rst_n),
        .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hexcl(hexcl), .hready(hready), .hresp(hresp),
        .hwdata(hwdata), .hrdata(hrdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // AHB slave: reads return {A5A5, addr[11:2]+1}; writes land in mem[addr[13:2]].
    logic [31:0] mem [0:4095];
    logic        dp_v = 1'b0, dp_w = 1'b0, eph = 1'b0;
    logic [11:0] dp_a = '0;
    int          wcnt = 0;
    int          nxfer = 0;
    int          ws = 0;
    int          err_at = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_v <= 1'b0; eph <= 1'b0; wcnt <= 0;
            hready <= 1'b1; hresp <= 1'b0; hrdata <= '0;
        end else if (hready) begin
            if (dp_v && dp_w && !hresp) mem[dp_a] = hwdata;
            if (htrans == 2'b10) begin
                dp_v  <= 1'b1;
                dp_w  <= hwrite;
                dp_a  <= haddr[13:2];
                nxfer <= nxfer + 1;
                hrdata <= {16'hA5A5, 6'd0, 10'(haddr[11:2] + 10'd1)};
                if (err_at != 0 && nxfer + 1 == err_at) begin
                    hready <= 1'b0; hresp <= 1'b1; eph <= 1'b1;
                end else if (ws > 0) begin
                    hready <= 1'b0; hresp <= 1'b0; wcnt <= ws - 1;
                end else begin
                    hready <= 1'b1; hresp <= 1'b0;
                end
            end else begin
                dp_v <= 1'b0; hready <= 1'b1; hresp <= 1'b0;
            end
        end else begin
            if (eph) begin
                hready <= 1'b1; hresp <= 1'b1; eph <= 1'b0;
            end else if (wcnt > 0) begin
                wcnt <= wcnt - 1;
            end else begin
                hready <= 1'b1;
            end
        end
    end

    // Timing and bus-stability monitor.
    int          cyc = 0, epoch = 0, ep_first = -1, ep_irq = -1, t_first = 0, t_irq = 0, stab_err = 0;
    logic        p_lo = 1'b0;
    logic [66:0] p_bus = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (htrans == 2'b10 && ep_first != epoch) begin
            ep_first <= epoch; t_first <= cyc;
        end
        if (irq && ep_irq != epoch) begin
            ep_irq <= epoch; t_irq <= cyc;
        end
        if (p_lo && ({haddr, hwdata, htrans, hwrite} !== p_bus)) stab_err <= stab_err + 1;
        p_lo  <= !hready;
        p_bus <= {haddr, hwdata, htrans, hwrite};
    end

    logic slverr_q = 1'b0;

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 slverr_q = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] v;
        apb_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            apb_read(A_CSR, v);
            n++;
        end while (v[1] && n < 300);
        check(tag, {31'd0, v[1]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n0;
        int s0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_consts", {20'd0, hsize, hburst, hprot, hmastlock, hexcl, pready},
              {20'd0, 3'd2, 3'd0, 4'b0011, 1'b0, 1'b0, 1'b1});
        @(negedge clk) rst_n = 1'b1;
        rd_check("rst_csr", A_CSR, 32'h0);
        rd_check("rst_count", A_CNT, 32'h0);
        rd_check("pattern_off", A_PAT, 32'h0);

        // Three-word zero-wait copy.
        apb_write(A_SRC, 32'h0000_1003);
        check("src_wr_slverr", {31'd0, slverr_q}, 32'd0);
        rd_check("src_align", A_SRC, 32'h0000_1000);
        apb_write(A_DST, 32'h0000_2000);
        apb_write(A_CNT, 32'd3);
        apb_write(A_BAD, 32'hFFFF_FFFF);
        check("bad_slverr", {31'd0, slverr_q}, 32'd0);
        rd_check("bad_read", A_BAD, 32'h0);
        apb_write(A_CSR, 32'h10);
        epoch = 1;
        apb_write(A_CSR, 32'h11);
        wait_idle("t1_busy");
        check("t1_cycles", t_irq - t_first, 32'd12);
        check("t1_mem0", mem[12'h800], 32'hA5A5_0001);
        check("t1_mem1", mem[12'h801], 32'hA5A5_0002);
        check("t1_mem2", mem[12'h802], 32'hA5A5_0003);
        rd_check("t1_csr", A_CSR, 32'h14);
        rd_check("t1_count", A_CNT, 32'h0);
        rd_check("t1_src", A_SRC, 32'h100C);
        rd_check("t1_dst", A_DST, 32'h200C);
        check("t1_irq", {31'd0, irq}, 32'd1);

        // Zero count: DONE immediately, no bus activity.
        apb_write(A_CSR, 32'h14);
        check("t2_irq_clr", {31'd0, irq}, 32'd0);
        n0 = nxfer;
        apb_write(A_CSR, 32'h11);
        check("t2_irq_set", {31'd0, irq}, 32'd1);
        repeat (4) @(posedge clk);
        check("t2_noxfer", nxfer - n0, 32'd0);
        rd_check("t2_csr", A_CSR, 32'h14);
        apb_write(A_CSR, 32'h14);
        check("t2_irq_w1c", {31'd0, irq}, 32'd0);

        // Two wait states per data phase, one word.
        ws = 2;
        apb_write(A_SRC, 32'h1100);
        apb_write(A_DST, 32'h2100);
        apb_write(A_CNT, 32'd1);
        s0 = stab_err;
        epoch = 2;
        apb_write(A_CSR, 32'h11);
        wait_idle("t3_busy");
        check("t3_cycles", t_irq - t_first, 32'd8);
        check("t3_mem", mem[12'h840], 32'hA5A5_0041);
        check("t3_stable", stab_err - s0, 32'd0);
        rd_check("t3_csr", A_CSR, 32'h14);
        apb_write(A_CSR, 32'h14);
        ws = 0;

        // Error on the second word's write data phase.
        apb_write(A_SRC, 32'h1000);
        apb_write(A_DST, 32'h2000);
        apb_write(A_CNT, 32'd4);
        n0 = nxfer;
        err_at = nxfer + 4;
        apb_write(A_CSR, 32'h11);
        wait_idle("t4_busy");
        repeat (4) @(posedge clk);
        check("t4_nxfer", nxfer - n0, 32'd4);
        rd_check("t4_csr", A_CSR, 32'h18);
        rd_check("t4_count", A_CNT, 32'd3);
        rd_check("t4_dst", A_DST, 32'h2004);
        rd_check("t4_src", A_SRC, 32'h1004);
        check("t4_irq", {31'd0, irq}, 32'd1);
        err_at = 0;
        apb_write(A_CSR, 32'h18);
        rd_check("t4_w1c", A_CSR, 32'h10);

        // Abort during word 2 of five.
        apb_write(A_SRC, 32'h1000);
        apb_write(A_DST, 32'h2000);
        apb_write(A_CNT, 32'd5);
        apb_write(A_CSR, 32'h11);
        repeat (4) @(negedge clk);
        apb_write(A_CSR, 32'h30);
        wait_idle("t5_busy");
        rd_check("t5_csr", A_CSR, 32'h10);
        rd_check("t5_count", A_CNT, 32'd3);
        rd_check("t5_src", A_SRC, 32'h1008);
        check("t5_irq", {31'd0, irq}, 32'd0);

        // Register write while busy is refused.
        ws = 6;
        apb_write(A_SRC, 32'h1000);
        apb_write(A_CNT, 32'd2);
        apb_write(A_CSR, 32'h11);
        apb_write(A_SRC, 32'h5550);
        check("t6_slverr", {31'd0, slverr_q}, 32'd1);
        rd_check("t6_src_kept", A_SRC, 32'h1000);
        wait_idle("t6_busy");
        rd_check("t6_csr", A_CSR, 32'h14);
        rd_check("t6_src_end", A_SRC, 32'h1008);
        apb_write(A_CSR, 32'h14);
        ws = 0;

`ifdef HAZARD3_DMA_FILL_EN
        // Pattern fill: writes only, two cycles per word.
        apb_write(A_PAT, 32'hDEAD_BEEF);
        apb_write(A_DST, 32'h3000);
        apb_write(A_CNT, 32'd2);
        n0 = nxfer;
        epoch = 3;
        apb_write(A_CSR, 32'h51);
        wait_idle("t8_busy");
        check("t8_cycles", t_irq - t_first, 32'd4);
        check("t8_nxfer", nxfer - n0, 32'd2);
        check("t8_mem0", mem[12'hC00], 32'hDEAD_BEEF);
        check("t8_mem1", mem[12'hC01], 32'hDEAD_BEEF);
        rd_check("t8_csr", A_CSR, 32'h54);
        apb_write(A_CSR, 32'h04);
`endif

        // Asynchronous reset in the middle of a transfer.
        apb_write(A_SRC, 32'h1000);
        apb_write(A_DST, 32'h2000);
        apb_write(A_CNT, 32'd3);
        apb_write(A_CSR, 32'h11);
        repeat (3) @(negedge clk);
        check("t7_pre_nonseq", {30'd0, htrans}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("t7_htrans", {30'd0, htrans}, 32'd0);
        check("t7_hwrite", {31'd0, hwrite}, 32'd0);
        check("t7_haddr", haddr, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rd_check("t7_csr", A_CSR, 32'h0);
        rd_check("t7_count", A_CNT, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
